// File: rtl/lane_drain_sequencer_if.sv
// Output stream of the lane drain sequencer: one 32-bit lane word per beat,
// valid/ready handshake, lane index and last-beat marker travel with the word.
interface lane_drain_sequencer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_lane;
    logic        out_last;

    // Sequencer side drives the beat, consumer drives ready.
    modport master (
        output out_valid,
        output out_data,
        output out_lane,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_lane,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/lane_drain_sequencer.sv
// Lane drain sequencer: captures a K x 32 b vector on start and emits its lanes
// one per beat, starting at first_lane and wrapping modulo K, for
// min(lane_count, K) beats, then pulses done for one cycle.
// Optional feature macro LANE_DRAIN_STRIDE_EN adds a lane_stride input; the
// lane step becomes (stride mod K), with 0 forced to 1. Without it the step is 1.
// All outputs are registered; out_lane also feeds a shared lane-select mux.
module lane_drain_sequencer #(
    parameter int unsigned K = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          first_lane,
    input  logic [31:0]          lane_count,
    input  logic [32*K-1:0]      vdata_in,
`ifdef LANE_DRAIN_STRIDE_EN
    input  logic [31:0]          lane_stride,
`endif
    output logic                 busy,
    output logic                 done,
    lane_drain_sequencer_if.master stream
);

    localparam logic [31:0] KW = 32'(K);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [32*K-1:0]   vec_q;
    logic [31:0]       lane_q;
    logic [31:0]       rem_q;
    logic [31:0]       step;
    logic [31:0]       start_lane;
    logic [31:0]       start_rem;
    logic [31:0]       next_lane;

    // Select one 32-bit lane; indices >= K never reach here.
    function automatic logic [31:0] pick(input logic [32*K-1:0] v, input logic [31:0] idx);
        logic [31:0] w;
        w = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (idx == 32'(i)) begin
                w = v[32*i +: 32];
            end
        end
        return w;
    endfunction

`ifdef LANE_DRAIN_STRIDE_EN
    logic [31:0] step_q;
    logic [31:0] start_step;

    // Stride reduced modulo K; a zero step would stall on one lane, so use 1.
    always_comb begin
        start_step = lane_stride % KW;
        if (start_step == '0) begin
            start_step = 32'd1;
        end
    end

    assign step = step_q;
`else
    assign step = 32'd1;
`endif

    // Start-time lane/count clamping and the wrapped next lane index.
    always_comb begin
        start_lane = (first_lane < KW) ? first_lane : '0;
        start_rem  = (lane_count > KW) ? KW : lane_count;
        next_lane  = lane_q + step;
        if (next_lane >= KW) begin
            next_lane = next_lane - KW;
        end
    end

    // Sequencer FSM with registered outputs; synchronous active-low reset wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= StIdle;
            vec_q            <= '0;
            lane_q           <= '0;
            rem_q            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            stream.out_lane  <= '0;
            stream.out_last  <= 1'b0;
`ifdef LANE_DRAIN_STRIDE_EN
            step_q           <= 32'd1;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        vec_q           <= vdata_in;
                        lane_q          <= start_lane;
                        rem_q           <= start_rem;
                        busy            <= 1'b1;
                        stream.out_lane <= start_lane;
                        stream.out_data <= pick(vdata_in, start_lane);
`ifdef LANE_DRAIN_STRIDE_EN
                        step_q          <= start_step;
`endif
                        if (lane_count == '0) begin
                            state_q          <= StDone;
                            done             <= 1'b1;
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                        end else begin
                            state_q          <= StRun;
                            stream.out_valid <= 1'b1;
                            stream.out_last  <= (start_rem == 32'd1);
                        end
                    end
                end
                StRun: begin
                    // out_valid is always high here, so ready alone means transfer.
                    if (stream.out_ready) begin
                        rem_q           <= rem_q - 32'd1;
                        lane_q          <= next_lane;
                        stream.out_lane <= next_lane;
                        stream.out_data <= pick(vec_q, next_lane);
                        if (stream.out_last) begin
                            state_q          <= StDone;
                            done             <= 1'b1;
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                        end else begin
                            stream.out_last <= (rem_q == 32'd2);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_drain_sequencer.sv
// Bench for lane_drain_sequencer: a queue-based model of the expected beat
// stream is checked against the DUT every cycle, plus literal lane sequences
// for the directed cases.
module tb_lane_drain_sequencer;
    localparam int unsigned K = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [31:0]       first_lane;
    logic [31:0]       lane_count;
    logic [32*K-1:0]   vdata;
    logic [31:0]       stride_in;
    logic              busy;
    logic              done;

    lane_drain_sequencer_if ldq ();

    lane_drain_sequencer #(.K(K)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_lane (first_lane),
        .lane_count (lane_count),
        .vdata_in   (vdata),
`ifdef LANE_DRAIN_STRIDE_EN
        .lane_stride(stride_in),
`endif
        .busy       (busy),
        .done       (done),
        .stream     (ldq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    bit chk_en = 1'b0;
    int ready_mode = 0;
    int ready_ph = 0;

    typedef struct {
        logic [31:0] lane;
        logic [31:0] data;
    } beat_t;

    beat_t m_q[$];    // beats still to be emitted, head is the current one
    bit    m_done;    // done pulse due this cycle
    beat_t obs[$];    // beats the DUT actually transferred

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: on an accepted start, the whole beat list is computed up front.
    always @(posedge clk) begin
        if (!reset) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            if (ldq.out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (start) begin
            int unsigned n, l, s;
            beat_t b;
            n = (lane_count > K) ? K : lane_count;
            l = (first_lane < K) ? first_lane : 0;
`ifdef LANE_DRAIN_STRIDE_EN
            s = stride_in % K;
            if (s == 0) s = 1;
`else
            s = 1;
`endif
            for (int unsigned i = 0; i < n; i++) begin
                b.lane = l;
                b.data = vdata[32*l +: 32];
                m_q.push_back(b);
                l = (l + s) % K;
            end
            if (n == 0) m_done = 1'b1;
        end
    end

    // Consumer ready pattern, changed on the falling edge.
    always @(negedge clk) begin
        case (ready_mode)
            0: ldq.out_ready = 1'b1;
            1: begin
                ldq.out_ready = (ready_ph % 4 == 0) || (ready_ph % 4 == 3);
                ready_ph++;
            end
            default: ldq.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Compare and monitor, mid-cycle away from the active edge.
    always begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            bit ev;
            ev = (m_q.size() > 0);
            chk("out_valid", ldq.out_valid, ev);
            chk("busy", busy, ev || m_done);
            chk("done", done, m_done);
            chk("out_last", ldq.out_last, ev && (m_q.size() == 1));
            if (ev && ldq.out_valid) begin
                chk("out_lane", ldq.out_lane, m_q[0].lane);
                chk("out_data", ldq.out_data, m_q[0].data);
            end
            if (ldq.out_valid && ldq.out_ready) begin
                beat_t b;
                b.lane = ldq.out_lane;
                b.data = ldq.out_data;
                obs.push_back(b);
            end
            if (done) n_done++;
        end
    end

    task automatic set_pattern();
        for (int i = 0; i < K; i++) vdata[32*i +: 32] = 32'hA000_0000 + i;
    endtask

    task automatic scramble();
        for (int i = 0; i < K; i++) vdata[32*i +: 32] = $urandom;
    endtask

    // One drain; vdata is scrambled after capture; optional start while busy.
    task automatic run_drain(input int unsigned fl, input int unsigned cnt,
                             input int unsigned st, input bit inject);
        int d0;
        int waited;
        d0 = n_done;
        obs.delete();
        @(negedge clk); #2;
        start = 1'b1; first_lane = fl; lane_count = cnt; stride_in = st;
        @(negedge clk); #2;
        start = 1'b0;
        scramble();
        waited = 0;
        while (n_done == d0 && waited < 300) begin
            if (inject && waited == 2) begin
                start = 1'b1; first_lane = 3; lane_count = 2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #2;
            waited++;
        end
        start = 1'b0;
        chk("drain_finished", (n_done != d0), 1);
    endtask

    task automatic chk_lanes(input string name, input int unsigned e[$], input bit pat);
        chk({name, "_count"}, obs.size(), e.size());
        for (int i = 0; i < e.size() && i < obs.size(); i++) begin
            chk({name, "_lane"}, obs[i].lane, e[i]);
        end
        if (pat) begin
            for (int i = 0; i < obs.size(); i++) begin
                chk({name, "_data"}, obs[i].data, 32'hA000_0000 + obs[i].lane);
            end
        end
    endtask

    initial begin
        int unsigned e[$];
        int d0;
        int w;
        reset = 1'b0; start = 1'b0; first_lane = '0; lane_count = '0;
        stride_in = 32'd1; vdata = '0;
        ldq.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", ldq.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", ldq.out_last, 0);
        chk("rst_data", ldq.out_data, 0);
        chk("rst_lane", ldq.out_lane, 0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Full drain, continuous ready.
        set_pattern();
        run_drain(0, 8, 1, 0);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_lanes("full", e, 1);

        set_pattern();
        run_drain(6, 4, 1, 0);
        e = '{6, 7, 0, 1};
        chk_lanes("wrap", e, 1);

        ready_mode = 1; ready_ph = 0;
        set_pattern();
        run_drain(2, 5, 1, 0);
        e = '{2, 3, 4, 5, 6};
        chk_lanes("backpressure", e, 1);
        ready_mode = 0;

        set_pattern();
        run_drain(0, 0, 1, 0);
        chk("zero_len_beats", obs.size(), 0);

        set_pattern();
        run_drain(9, 3, 1, 0);
        e = '{0, 1, 2};
        chk_lanes("first_oor", e, 1);

        set_pattern();
        run_drain(4, 20, 1, 0);
        e = '{4, 5, 6, 7, 0, 1, 2, 3};
        chk_lanes("clip", e, 1);

        set_pattern();
        d0 = n_done;
        run_drain(0, 4, 1, 1);
        e = '{0, 1, 2, 3};
        chk_lanes("start_in_run", e, 1);
        repeat (3) @(negedge clk);
        #2;
        chk("start_in_run_idle", busy, 0);
        chk("start_in_run_dones", n_done - d0, 1);

        // Reset in the middle of a drain.
        set_pattern();
        obs.delete();
        d0 = n_done;
        @(negedge clk); #2;
        start = 1'b1; first_lane = 0; lane_count = 8; stride_in = 1;
        @(negedge clk); #2;
        start = 1'b0;
        w = 0;
        while (obs.size() < 3 && w < 50) begin
            @(negedge clk); #2;
            w++;
        end
        chk("mid_reset_reached", (obs.size() >= 3), 1);
        reset = 1'b0;
        @(negedge clk); #2;
        chk("mid_reset_valid", ldq.out_valid, 0);
        chk("mid_reset_busy", busy, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("mid_reset_no_done", n_done - d0, 0);
        set_pattern();
        run_drain(5, 3, 1, 0);
        e = '{5, 6, 7};
        chk_lanes("after_reset", e, 1);

`ifdef LANE_DRAIN_STRIDE_EN
        set_pattern();
        run_drain(0, 8, 3, 0);
        e = '{0, 3, 6, 1, 4, 7, 2, 5};
        chk_lanes("stride3", e, 1);
        set_pattern();
        run_drain(0, 8, 0, 0);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_lanes("stride0", e, 1);
`endif

        // Randomized drains against the model.
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            scramble();
            run_drain($urandom_range(0, 11), $urandom_range(0, 12),
                      $urandom_range(0, 20), ($urandom_range(0, 2) == 0));
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
